// File: rtl/axi_llc_sram_arb.sv
// axi_llc_sram_arb: round-robin arbiter in front of one single-ported LLC SRAM macro.
// The winner is held across SRAM stalls. Read data returns ReadLatency cycles after
// the handshake and is steered to the requester that issued the read.
// Optional feature macro: AXI_LLC_SRAM_ARB_PERF_EN adds per-requester saturating stall counters.
module axi_llc_sram_arb #(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned ByteWidth   = 8,
    parameter int unsigned ReadLatency = 1,
    localparam int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth    = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned IdxWidth   = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          busy_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    output logic [BeWidth-1:0]            sram_be_o,
    input  logic                          sram_gnt_i,
    input  logic [DataWidth-1:0]          sram_rdata_i
`ifdef AXI_LLC_SRAM_ARB_PERF_EN
    ,
    output logic [NumReq*32-1:0]          stall_cnt_o
`endif
);

    logic [IdxWidth-1:0] rr_ptr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic                lock_q;
    logic [IdxWidth-1:0] winner;
    logic [IdxWidth-1:0] cand_idx;
    int unsigned         cand;
    logic                active;
    logic                handshake;

    logic [ReadLatency-1:0] pipe_vld_q;
    logic [IdxWidth-1:0]    pipe_idx_q [ReadLatency];

    // Winner selection: locked requester, else first requester at or after rr_ptr_q.
    // The scan runs from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        winner   = rr_ptr_q;
        cand     = 0;
        cand_idx = '0;
        if (lock_q) begin
            winner = lock_idx_q;
        end else begin
            for (int unsigned i = NumReq; i > 0; i--) begin
                cand     = (32'(rr_ptr_q) + i - 1) % NumReq;
                cand_idx = IdxWidth'(cand);
                if (req_i[cand_idx]) winner = cand_idx;
            end
        end
    end

    // Request qualification: a locked requester that withdrew produces no SRAM access.
    always_comb begin
        if (rst_i) begin
            active = 1'b0;
        end else if (lock_q) begin
            active = req_i[lock_idx_q];
        end else begin
            active = |req_i;
        end
        handshake = active & sram_gnt_i;
    end

    // SRAM command mux and one-hot grant.
    always_comb begin
        sram_req_o   = active;
        sram_we_o    = we_i[winner];
        sram_addr_o  = addr_i[winner*AddrWidth +: AddrWidth];
        sram_wdata_o = wdata_i[winner*DataWidth +: DataWidth];
        sram_be_o    = be_i[winner*BeWidth +: BeWidth];
        gnt_o        = '0;
        if (handshake) gnt_o[winner] = 1'b1;
    end

    // Round-robin pointer and stall lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (handshake) begin
            lock_q <= 1'b0;
            if (32'(winner) == NumReq - 1) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= winner + 1'b1;
            end
        end else if (active) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end else begin
            lock_q <= 1'b0;
        end
    end

    // Read-return valid pipe; cleared by reset so in-flight reads are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= handshake & ~sram_we_o;
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Read-return requester index pipe, qualified by the valid pipe.
    always_ff @(posedge clk_i) begin
        pipe_idx_q[0] <= winner;
        for (int unsigned i = 1; i < ReadLatency; i++) begin
            pipe_idx_q[i] <= pipe_idx_q[i-1];
        end
    end

    // Response steering and status.
    always_comb begin
        rvalid_o = '0;
        if (pipe_vld_q[ReadLatency-1]) rvalid_o[pipe_idx_q[ReadLatency-1]] = 1'b1;
        rdata_o = sram_rdata_i;
        busy_o  = lock_q | (|pipe_vld_q);
    end

`ifdef AXI_LLC_SRAM_ARB_PERF_EN
    logic [31:0] stall_cnt_q [NumReq];

    // Saturating count of cycles each requester waits without a grant.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (rst_i) begin
                stall_cnt_q[k] <= '0;
            end else if (req_i[k] && !gnt_o[k] && (stall_cnt_q[k] != '1)) begin
                stall_cnt_q[k] <= stall_cnt_q[k] + 32'd1;
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        stall_cnt_o = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            stall_cnt_o[k*32 +: 32] = stall_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_axi_llc_sram_arb.sv
// Testbench for axi_llc_sram_arb: directed reset/fairness/lock/latency/reset-in-flight
// scenarios followed by randomized traffic, checked against a transaction-level model.
// Stall counters are checked when AXI_LLC_SRAM_ARB_PERF_EN is defined.
module tb_axi_llc_sram_arb;

    localparam int NREQ = 2;
    localparam int NW   = 64;
    localparam int DW   = 32;
    localparam int BYW  = 8;
    localparam int LAT  = 3;
    localparam int AW   = 6;
    localparam int BEW  = 4;

    logic clk, rst;
    logic [NREQ-1:0] req, we;
    logic [AW-1:0]   addr  [NREQ];
    logic [DW-1:0]   wdata [NREQ];
    logic [BEW-1:0]  be    [NREQ];
    logic [NREQ*AW-1:0]  addr_bus;
    logic [NREQ*DW-1:0]  wdata_bus;
    logic [NREQ*BEW-1:0] be_bus;
    logic [NREQ-1:0] gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            busy, sram_req, sram_we, sram_gnt;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata, sram_rdata;
    logic [BEW-1:0]  sram_be;
`ifdef AXI_LLC_SRAM_ARB_PERF_EN
    logic [NREQ*32-1:0] stall_cnt;
`endif

    axi_llc_sram_arb #(
        .NumReq(NREQ), .NumWords(NW), .DataWidth(DW), .ByteWidth(BYW), .ReadLatency(LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr_bus),
        .wdata_i(wdata_bus), .be_i(be_bus), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .busy_o(busy), .sram_req_o(sram_req), .sram_we_o(sram_we),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
        .sram_gnt_i(sram_gnt), .sram_rdata_i(sram_rdata)
`ifdef AXI_LLC_SRAM_ARB_PERF_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            addr_bus[k*AW +: AW]   = addr[k];
            wdata_bus[k*DW +: DW]  = wdata[k];
            be_bus[k*BEW +: BEW]   = be[k];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // SRAM macro behaviour: byte-masked writes, reads delivered LAT cycles after handshake.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] rd_pipe [LAT];
    assign sram_rdata = rd_pipe[LAT-1];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= DW'($urandom);
        if (sram_req && sram_gnt) begin
            if (sram_we) begin
                for (int b = 0; b < BEW; b++)
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
            end else begin
                rd_pipe[0] <= mem[sram_addr];
            end
        end
    end

    // Bookkeeping and reference state.
    int n_cmp = 0;
    int n_err = 0;
    typedef struct { int idx; logic [DW-1:0] data; int due; } rd_t;
    rd_t exp_q [$];
    logic [DW-1:0] ref_mem [NW];
    int  m_ptr  = 0;
    int  m_lock = -1;
    bit  granted [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: reference arbitration per cycle and scoreboard of read returns.
    always @(negedge clk) begin : mon
        int  win;
        bit  act, found;
        bit  exp_busy;
        rd_t e;
        logic [NREQ-1:0] oh;
        if (cycle > 0) begin
            exp_busy = (m_lock >= 0) || (exp_q.size() > 0);
            if (rvalid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(rvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("rvalid_idx", 64'(rvalid), 64'(oh));
                    check("rdata", 64'(rdata), 64'(e.data));
                    check("return_cycle", 64'(cycle), 64'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                check("rvalid_missing", 64'(rvalid), 64'(oh));
            end

            if (rst) begin
                check("gnt_in_reset", 64'(gnt), 64'd0);
                check("sram_req_in_reset", 64'(sram_req), 64'd0);
                exp_q.delete();
                m_ptr  = 0;
                m_lock = -1;
                for (int k = 0; k < NREQ; k++) granted[k] = 1'b0;
            end else begin
                check("busy", 64'(busy), 64'(exp_busy));
                win = m_ptr;
                found = 1'b0;
                if (m_lock >= 0) begin
                    win = m_lock;
                    act = req[m_lock];
                end else begin
                    act = |req;
                    for (int o = 0; o < NREQ; o++) begin
                        if (!found && req[(m_ptr + o) % NREQ]) begin
                            win = (m_ptr + o) % NREQ;
                            found = 1'b1;
                        end
                    end
                end
                oh = '0;
                if (act && sram_gnt) oh[win] = 1'b1;
                check("gnt", 64'(gnt), 64'(oh));
                check("sram_req", 64'(sram_req), 64'(act));
                if (act) begin
                    check("sram_addr", 64'(sram_addr), 64'(addr[win]));
                    check("sram_we", 64'(sram_we), 64'(we[win]));
                    if (we[win]) begin
                        check("sram_wdata", 64'(sram_wdata), 64'(wdata[win]));
                        check("sram_be", 64'(sram_be), 64'(be[win]));
                    end
                end
                if (act && sram_gnt) begin
                    granted[win] = 1'b1;
                    m_ptr  = (win + 1) % NREQ;
                    m_lock = -1;
                    if (we[win]) begin
                        for (int b = 0; b < BEW; b++)
                            if (be[win][b]) ref_mem[addr[win]][b*8 +: 8] = wdata[win][b*8 +: 8];
                    end else begin
                        e.idx  = win;
                        e.data = ref_mem[addr[win]];
                        e.due  = cycle + LAT;
                        exp_q.push_back(e);
                    end
                end else if (act) begin
                    m_lock = win;
                end else begin
                    m_lock = -1;
                end
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int k, input bit r, input bit w, input int a);
        req[k]   = r;
        we[k]    = w;
        addr[k]  = AW'(a);
        wdata[k] = DW'($urandom);
        be[k]    = BEW'($urandom);
    endtask

    // mode 0: granted requesters issue another read; 1: random traffic; 2: go idle once granted.
    task automatic run(input int n, input int mode);
        repeat (n) begin
            tick();
            if (mode == 1) sram_gnt = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (granted[k] || !req[k]) begin
                    granted[k] = 1'b0;
                    case (mode)
                        0: set_txn(k, 1'b1, 1'b0, int'($urandom_range(0, 31)));
                        1: set_txn(k, $urandom_range(0, 9) < 6, 1'($urandom), int'($urandom_range(0, 31)));
                        default: req[k] = 1'b0;
                    endcase
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        for (int k = 0; k < NREQ; k++) begin
            granted[k] = 1'b0;
            set_txn(k, 1'b1, 1'b0, k);
        end
        rst = 1'b1;
        sram_gnt = 1'b1;

        // Reset with both requesting, then fairness with back-to-back reads.
        repeat (3) tick();
        rst = 1'b0;
        run(8, 0);
        run(LAT + 4, 2);

        // Stall lock: requester 0 stalled, requester 1 rises during the stall.
        sram_gnt = 1'b0;
        set_txn(0, 1'b1, 1'b0, 5);
        tick();
        tick();
        set_txn(1, 1'b1, 1'b0, 9);
        tick();
        tick();
        sram_gnt = 1'b1;
        run(LAT + 4, 2);

        // Write 0xA5.. to 0x12, then read it back on requester 0.
        set_txn(0, 1'b1, 1'b1, 'h12);
        wdata[0] = {(DW/8){8'hA5}};
        be[0] = '1;
        tick();
        set_txn(0, 1'b1, 1'b0, 'h12);
        tick();
        req[0] = 1'b0;
        granted[0] = 1'b0;
        run(LAT + 3, 2);

        // Reset while a read is in flight.
        set_txn(0, 1'b1, 1'b0, 'h12);
        tick();
        req[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(LAT + 4, 2);

`ifdef AXI_LLC_SRAM_ARB_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sram_gnt = 1'b0;
        set_txn(0, 1'b1, 1'b0, 3);
        set_txn(1, 1'b1, 1'b0, 4);
        repeat (5) tick();
        sram_gnt = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        check("stall_cnt_1", 64'(stall_cnt[63:32]), 64'd5);
        check("stall_cnt_0", 64'(stall_cnt[31:0]), 64'd5);
        run(LAT + 4, 2);
`endif

        // Randomized traffic with random SRAM back-pressure, then drain.
        run(600, 1);
        sram_gnt = 1'b1;
        run(LAT + 10, 2);
        check("leftover_reads", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
